ifq_fetch_ctrl: RTL
===================

// Module: ifq_fetch_ctrl
// PURPOSE
//  Instruction fetch queue controller. Sequences line reads from the instruction cache,
//  buffers the returned lines and hands single instructions with their PC to dispatch.
//  Handles branch redirects by aborting the cache, flushing the queue and dropping any
//  responses still in flight. Sits between the icache and the dispatch stage.
// PARAMETERS
//  W_DATA    32   instruction / PC width
//  W_LINE    128  cache line width (W_LINE/W_DATA = 4 words per line)
//  DEPTH     4    line buffer entries, power of 2, >= 2
//  CACHE_LAT 1    fixed cycles from icache_ren to icache_dout_valid (1 = icache with output reg)
// PORTS
//  clk               in  1      clock, all state on rising edge
//  reset             in  1      synchronous, active-high
//  icache_pcout      out 32     line-aligned fetch address {fetch_pc[31:4],4'h0}
//  icache_ren        out 1      line read request
//  icache_abort      out 1      cancel request, same cycle as redirect
//  icache_dout       in  128    returned line; word k = bits[32k+31:32k]
//  icache_dout_valid in  1      icache_dout valid this cycle
//  jmp_branch_valid  in  1      redirect request
//  jmp_branch_addr   in  32     redirect target; bits[1:0] ignored
//  dsp_ren           in  1      dispatch pops one instruction
//  dsp_inst          out 32     instruction at head
//  dsp_pc            out 32     PC of dsp_inst
//  dsp_empty         out 1      no instruction available
// BEHAVIOUR
//  Reset: icache_ren=0, icache_abort=0, dsp_empty=1, dsp_inst=0, dsp_pc=0, icache_pcout=0;
//   fetch_pc=0, queue empty, in-flight=0, state IDLE. Reset mid-operation discards all state.
//  FSM: IDLE -(always, 1 cycle)-> FETCH; FETCH -(jmp_branch_valid)-> FLUSH;
//   FLUSH holds exactly CACHE_LAT cycles (down-counter), then -> FETCH. Branch in FLUSH restarts it.
//  Credit: icache_ren = (state==FETCH) & ~jmp_branch_valid & (lines_held + in_flight < DEPTH).
//   On issue fetch_pc <= {fetch_pc[31:4]+1, 4'h0}; 32-bit wrap 0xFFFFFFF0 -> 0x0 allowed.
//  Response: icache_dout_valid writes line + its start word offset into tail. Only the first line
//   after reset/redirect may start mid-line (offset = fetch_pc[3:2] at issue); all others offset 0.
//   Response with no outstanding request is a protocol error (assertion).
//  Output: combinational from head; dsp_inst = head word[rd_word];
//   dsp_pc = {head_pc[31:4], rd_word, 2'b00}; dsp_empty = (lines_held==0).
//  Pop: dsp_ren & ~dsp_empty -> rd_word+1; at rd_word==3 head line retires, rd_word <= next offset.
//   dsp_ren while empty ignored. Pop of last word and response in same cycle: count unchanged.
//  Redirect (priority over issue, pop, response): cycle T jmp_branch_valid=1 -> icache_abort=1,
//   icache_ren=0 same cycle; at edge: queue cleared, fetch_pc <= {addr[31:2],2'b00}, enter FLUSH.
//   Responses arriving during T and FLUSH are dropped; in_flight cleared on FLUSH exit.
//   dsp_empty=1 from T+1 until new line returns.
//  Latency: first issue 1 cycle after IDLE; instruction visible CACHE_LAT+1 cycles after issue.
//   Steady state with dsp_ren=1 always: one instruction per cycle, no bubbles when DEPTH>=2.
// TESTING
//  1 cache model returns word k = line_addr+4k, CACHE_LAT=1; release reset at cycle 0, dsp_ren=1
//    -> ren at cycle 1, dsp_empty=0 at cycle 3, dsp_pc/dsp_inst = 0x0,0x4,0x8,... one per cycle.
//  2 dsp_ren=0 for 20 cycles -> exactly DEPTH=4 issues (0x00..0x30), ren then stays 0;
//    resume dsp_ren=1 -> 16 instructions in order 0x0..0x3C, no loss, no duplicate.
//  3 branch to 0x48 while 2 lines in flight/held -> abort=1 that cycle only, stale lines dropped;
//    next outputs PC 0x48, 0x4C, then 0x50 (new line), no PC < 0x48 appears.
//  4 branch, dsp_ren and icache_dout_valid all same cycle -> branch wins: no pop observed,
//    response dropped, dsp_empty=1 next cycle, first output PC = branch target.
//  5 branch addr 0x4B -> treated as 0x48; branch at 0xFFFFFFF0 -> next line fetched at 0x0.
//  6 reset asserted mid-stream for 1 cycle -> all outputs at reset values next cycle;
//    fetch restarts at 0x0 with same timing as scenario 1.

Source files
------------

// File: rtl/ifq_fetch_ctrl.sv
// Instruction fetch queue controller: issues icache line reads under a credit limit,
// buffers returned lines and presents one instruction plus its PC per cycle to dispatch.
module ifq_fetch_ctrl #(
    parameter int W_DATA    = 32,
    parameter int W_LINE    = 128,
    parameter int DEPTH     = 4,
    parameter int CACHE_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic [W_DATA-1:0] o_icache_pcout,
    output logic              o_icache_ren,
    output logic              o_icache_abort,
    input  logic [W_LINE-1:0] i_icache_dout,
    input  logic              i_icache_dout_valid,
    input  logic              i_jmp_branch_valid,
    input  logic [W_DATA-1:0] i_jmp_branch_addr,
    input  logic              i_dsp_ren,
    output logic [W_DATA-1:0] o_dsp_inst,
    output logic [W_DATA-1:0] o_dsp_pc,
    output logic              o_dsp_empty
);

    localparam int N_WORD = W_LINE / W_DATA;
    localparam int W_WORD = $clog2(N_WORD);
    localparam int W_OFF  = W_WORD + 2;
    localparam int W_LPC  = W_DATA - W_OFF;
    localparam int W_PTR  = $clog2(DEPTH);
    localparam int W_CNT  = $clog2(DEPTH + 1);
    localparam int W_FL   = (CACHE_LAT > 1) ? $clog2(CACHE_LAT) : 1;

    localparam logic [W_CNT:0]    DEPTH_C   = (W_CNT + 1)'(DEPTH);
    localparam logic [W_FL-1:0]   FL_LOAD   = W_FL'(CACHE_LAT - 1);
    localparam logic [W_WORD-1:0] LAST_WORD = W_WORD'(N_WORD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W_FL-1:0]    r_flush_cnt;

    logic [W_LPC-1:0]   r_fetch_line;
    logic [W_LPC-1:0]   r_resp_line;
    logic [W_WORD-1:0]  r_start_off;
    logic               r_need_off;
    logic [W_CNT-1:0]   r_in_flight;
    logic [W_CNT-1:0]   r_held;
    logic [W_PTR-1:0]   r_wr_ptr;
    logic [W_PTR-1:0]   r_rd_ptr;
    logic [W_WORD-1:0]  r_rd_word;

    logic [W_LINE-1:0]  r_mem [DEPTH];
    logic [W_LPC-1:0]   r_lpc [DEPTH];

    logic               w_room;
    logic               w_drop;
    logic               w_wr;
    logic               w_pop;
    logic               w_retire;
    logic               w_flush_exit;
    logic [N_WORD-1:0][W_DATA-1:0] w_head_words;
    logic               w_unused;

    assign w_unused = ^i_jmp_branch_addr[1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_jmp_branch_valid)
                r_flush_cnt <= FL_LOAD;
            else if (r_state == S_FLUSH && r_flush_cnt != '0)
                r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_FETCH;
            S_FLUSH: if (r_flush_cnt == '0) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_jmp_branch_valid)
            w_state_nxt = S_FLUSH;
    end

    // Credit counts lines already buffered plus lines still on their way back.
    assign w_room       = ({1'b0, r_held} + {1'b0, r_in_flight}) < DEPTH_C;
    assign o_icache_ren = (r_state == S_FETCH) && !i_jmp_branch_valid && w_room;
    assign o_icache_abort = i_jmp_branch_valid;
    assign o_icache_pcout = {r_fetch_line, {W_OFF{1'b0}}};

    assign w_drop       = i_jmp_branch_valid || (r_state == S_FLUSH);
    assign w_wr         = i_icache_dout_valid && !w_drop;
    assign w_pop        = i_dsp_ren && !o_dsp_empty && !i_jmp_branch_valid;
    assign w_retire     = w_pop && (r_rd_word == LAST_WORD);
    assign w_flush_exit = (r_state == S_FLUSH) && (r_flush_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_line <= '0;
            r_resp_line  <= '0;
            r_start_off  <= '0;
            r_need_off   <= 1'b1;
            r_in_flight  <= '0;
            r_held       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_word    <= '0;
        end else if (i_jmp_branch_valid) begin
            r_fetch_line <= i_jmp_branch_addr[W_DATA-1:W_OFF];
            r_resp_line  <= i_jmp_branch_addr[W_DATA-1:W_OFF];
            r_start_off  <= i_jmp_branch_addr[W_OFF-1:2];
            r_need_off   <= 1'b1;
            r_held       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rd_word    <= '0;
        end else begin
            if (o_icache_ren)
                r_fetch_line <= r_fetch_line + W_LPC'(1);

            if (w_flush_exit)
                r_in_flight <= '0;
            else
                r_in_flight <= r_in_flight + W_CNT'(o_icache_ren) - W_CNT'(w_wr);

            if (w_wr) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_resp_line <= r_resp_line + W_LPC'(1);
                r_need_off  <= 1'b0;
            end

            r_held <= r_held + W_CNT'(w_wr) - W_CNT'(w_retire);

            if (w_retire)
                r_rd_ptr <= r_rd_ptr + 1'b1;

            // Only the first line after a redirect can start mid-line, and it always lands
            // in an empty queue, so every later head starts at word 0.
            if (w_retire)
                r_rd_word <= '0;
            else if (w_pop)
                r_rd_word <= r_rd_word + 1'b1;
            else if (w_wr && r_held == '0)
                r_rd_word <= r_need_off ? r_start_off : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_icache_dout;
            r_lpc[r_wr_ptr] <= r_resp_line;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            assert (!i_icache_dout_valid || r_in_flight != '0)
                else $error("icache response with no outstanding request");
    end

    assign w_head_words = r_mem[r_rd_ptr];
    assign o_dsp_empty  = (r_held == '0);
    assign o_dsp_inst   = o_dsp_empty ? '0 : w_head_words[r_rd_word];
    assign o_dsp_pc     = o_dsp_empty ? '0 : {r_lpc[r_rd_ptr], r_rd_word, 2'b00};

endmodule
